set_assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-back / write-allocate cache with true-LRU replacement, sitting between a line-granular requester and a line-granular memory port. It is the configurable successor of the fixed 32 KB 4-way cache. It adds:
- a registered FSM with explicit valid/ready handshakes on both sides;
- byte-strobed partial-line writes;
- invalid-way-first victim selection;
- saturating hit/miss counters.

---
 rtl/set_assoc_cache.sv | 214 +++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache, true-LRU, invalid-way-first victim.
// Hit latency 2 cycles; a miss adds an optional writeback and then a fill, each fully handshaken.
// req_ready is high only in IDLE. Memory commands are held stable until mem_req_ready. Responses cannot be back-pressured.
module set_assoc_cache #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int SETS       = 128,
    parameter int WAYS       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [8*LINE_BYTES-1:0] req_wdata,
    input  logic [LINE_BYTES-1:0]   req_wstrb,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [8*LINE_BYTES-1:0] resp_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_write,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic [8*LINE_BYTES-1:0] mem_wdata,
    input  logic                    mem_resp_valid,
    input  logic [8*LINE_BYTES-1:0] mem_rdata,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
);
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int AGE_W  = $clog2(WAYS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB, S_FILL_REQ, S_FILL_WAIT, S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [LINE_W-1:0] data_mem  [SETS][WAYS];
    logic [AGE_W-1:0]  age_mem   [SETS][WAYS];
    logic [WAYS-1:0]   valid_mem [SETS];
    logic [WAYS-1:0]   dirty_mem [SETS];

    logic [ADDR_W-OFF_W-1:0] line_q;
    logic                    write_q;
    logic [LINE_W-1:0]       wdata_q;
    logic [LINE_BYTES-1:0]   wstrb_q;
    logic [AGE_W-1:0]        victim_q;
    logic                    resp_hit_q;
    logic [LINE_W-1:0]       resp_line_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic [AGE_W-1:0]  hit_way;
    logic [AGE_W-1:0]  victim_way;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] fill_line;
    logic              install;
    logic              touch_en;
    logic [AGE_W-1:0]  touch_way;
    logic              unused_addr_off;

    assign unused_addr_off = ^req_addr[OFF_W-1:0];

    function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0]     base,
                                                input logic [LINE_W-1:0]     wd,
                                                input logic [LINE_BYTES-1:0] be);
        merge = base;
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (be[b]) merge[8*b +: 8] = wd[8*b +: 8];
        end
    endfunction

    assign idx = line_q[IDX_W-1:0];
    assign tag = line_q[ADDR_W-OFF_W-1 -: TAG_W];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // Oldest way by default; any invalid way overrides it, lowest index last so it wins.
    always_comb begin
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_mem[idx][w] == AGE_W'(WAYS - 1)) victim_way = AGE_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mem[idx][w]) victim_way = AGE_W'(w);
        end
    end

    assign hit_line  = write_q ? merge(data_mem[idx][hit_way], wdata_q, wstrb_q)
                               : data_mem[idx][hit_way];
    assign fill_line = write_q ? merge(mem_rdata, wdata_q, wstrb_q) : mem_rdata;
    assign install   = (state == S_FILL_WAIT) && mem_resp_valid;
    assign touch_en  = ((state == S_LOOKUP) && hit) || install;
    assign touch_way = (state == S_LOOKUP) ? hit_way : victim_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (req_valid) state_nxt = S_LOOKUP;
            S_LOOKUP: begin
                if (hit)
                    state_nxt = S_RESP;
                else if (valid_mem[idx][victim_way] && dirty_mem[idx][victim_way])
                    state_nxt = S_WB;
                else
                    state_nxt = S_FILL_REQ;
            end
            S_WB:        if (mem_req_ready) state_nxt = S_FILL_REQ;
            S_FILL_REQ:  if (mem_req_ready) state_nxt = S_FILL_WAIT;
            S_FILL_WAIT: if (mem_resp_valid) state_nxt = S_RESP;
            S_RESP:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state == S_IDLE) && !rst;
        resp_valid    = (state == S_RESP);
        mem_req_valid = (state == S_WB) || (state == S_FILL_REQ);
        mem_req_write = (state == S_WB);
        mem_req_addr  = '0;
        mem_wdata     = '0;
        if (state == S_WB) begin
            mem_req_addr = {tag_mem[idx][victim_q], idx, {OFF_W{1'b0}}};
            mem_wdata    = data_mem[idx][victim_q];
        end else if (state == S_FILL_REQ) begin
            mem_req_addr = {line_q, {OFF_W{1'b0}}};
        end
    end

    assign resp_hit   = resp_hit_q;
    assign resp_rdata = resp_line_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            victim_q    <= '0;
            resp_hit_q  <= 1'b0;
            resp_line_q <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_mem[s][w] <= AGE_W'(w);
            end
        end else begin
            if (state == S_IDLE && req_valid) begin
                line_q  <= req_addr[ADDR_W-1:OFF_W];
                write_q <= req_write;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            if (state == S_LOOKUP) begin
                if (hit) begin
                    resp_hit_q  <= 1'b1;
                    resp_line_q <= hit_line;
                    if (write_q) dirty_mem[idx][hit_way] <= 1'b1;
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    victim_q <= victim_way;
                    if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                end
            end
            if (install) begin
                valid_mem[idx][victim_q] <= 1'b1;
                dirty_mem[idx][victim_q] <= write_q;
                resp_hit_q               <= 1'b0;
                resp_line_q              <= fill_line;
            end
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == touch_way)
                        age_mem[idx][w] <= '0;
                    else if (age_mem[idx][w] < age_mem[idx][touch_way])
                        age_mem[idx][w] <= age_mem[idx][w] + 1'b1;
                end
            end
        end
    end

    // Tags and line data carry no reset; valid bits alone decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (state == S_LOOKUP && hit && write_q) data_mem[idx][hit_way] <= hit_line;
        if (install) begin
            data_mem[idx][victim_q] <= fill_line;
            tag_mem[idx][victim_q]  <= tag;
        end
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: misses, hits, partial write, dirty/clean eviction, WB stall, reset in FILL_WAIT.
module tb_set_assoc_cache;
    typedef logic [511:0] line_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    line_t       req_wdata = '0;
    logic [63:0] req_wstrb = '0;
    logic        resp_valid;
    logic        resp_hit;
    line_t       resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    line_t       mem_wdata;
    logic        mem_resp_valid = 1'b0;
    line_t       mem_rdata = '0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always #5 clk = ~clk;

    set_assoc_cache dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          wb_cnt = 0;
    int          fill_cnt = 0;
    logic [31:0] wb_addr = '0;
    logic [31:0] fill_addr = '0;
    line_t       wb_data = '0;
    int          stall = 0;
    bit          rst_in_fill = 0;
    bit          aborted = 0;
    line_t       mem_model [logic [31:0]];

    localparam line_t LINE_A = {16{32'h5A5A_1040}};
    localparam line_t LINE_M = {{15{32'h5A5A_1040}}, 32'h5A5A_10FF};
    localparam line_t LINE_9 = {16{32'h5A5A_9040}};

    task automatic check(input string tag, input line_t got, input line_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic line_t mem_line(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {16{32'h5A5A_0000 ^ a}};
    endfunction

    // Drives one request and plays the memory side until the response (or a planted reset).
    task automatic do_req(input bit w, input logic [31:0] a, input line_t d, input logic [63:0] s,
                          output bit hit, output line_t rd, output int lat);
        bit          accepted = 0, done = 0, fillp = 0, stalled = 0;
        int          acc_cyc = 0;
        logic [31:0] fa = '0, p_addr = '0;
        logic        p_wr = 0;
        line_t       p_data = '0;
        hit = 0; rd = '0; lat = -1; aborted = 0;
        @(negedge clk);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (accepted) req_valid = 0;
            mem_req_ready = 0;
            mem_resp_valid = 0;
            if (stalled) begin
                check("hold_valid", mem_req_valid, 1);
                check("hold_write", mem_req_write, p_wr);
                check("hold_addr", mem_req_addr, p_addr);
                check("hold_wdata", mem_wdata, p_data);
                check("hold_req_ready", req_ready, 0);
            end
            stalled = 0;
            if (fillp) begin
                fillp = 0;
                if (rst_in_fill) begin
                    rst = 1; aborted = 1; done = 1;
                end else begin
                    mem_resp_valid = 1;
                    mem_rdata = mem_line(fa);
                end
            end else if (resp_valid) begin
                done = 1; hit = resp_hit; rd = resp_rdata; lat = cyc - acc_cyc;
            end
            if (!done && mem_req_valid) begin
                if (stall > 0) begin
                    stall--; stalled = 1;
                    p_addr = mem_req_addr; p_wr = mem_req_write; p_data = mem_wdata;
                end else begin
                    mem_req_ready = 1;
                    if (mem_req_write) begin
                        wb_cnt++; wb_addr = mem_req_addr; wb_data = mem_wdata;
                        mem_model[mem_req_addr] = mem_wdata;
                    end else begin
                        fill_cnt++; fill_addr = mem_req_addr; fillp = 1; fa = mem_req_addr;
                    end
                end
            end
            if (!done) begin
                if (!accepted && req_valid && req_ready) begin
                    accepted = 1; acc_cyc = cyc;
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
        req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
        if (!done) check("timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1;
        #1;
        check("rst_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 0;
        #1;
        check("rst_rel_ready", req_ready, 1);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
    endtask

    initial begin
        bit          h;
        line_t       rd;
        int          lat;
        int          wbs;
        logic [31:0] a;

        #2;
        check("reset_req_ready", req_ready, 0);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_mem_valid", mem_req_valid, 0);
        check("reset_mem_addr", mem_req_addr, 0);
        check("reset_hit_cnt", hit_cnt, 0);
        check("reset_miss_cnt", miss_cnt, 0);
        @(negedge clk);
        rst = 0;
        #1;
        check("release_req_ready", req_ready, 1);

        do_req(0, 32'h0000_1040, '0, 64'h0, h, rd, lat);
        check("miss1_hit", h, 0);
        check("miss1_rdata", rd, LINE_A);
        check("miss1_lat", lat, 4);
        check("miss1_fill_addr", fill_addr, 32'h0000_1040);
        check("miss1_wb_cnt", wb_cnt, 0);

        do_req(0, 32'h0000_1040, '0, 64'h0, h, rd, lat);
        check("hit1_hit", h, 1);
        check("hit1_rdata", rd, LINE_A);
        check("hit1_lat", lat, 2);
        check("hit1_hit_cnt", hit_cnt, 1);
        check("hit1_miss_cnt", miss_cnt, 1);

        do_req(1, 32'h0000_1040, {64{8'hFF}}, 64'h1, h, rd, lat);
        check("wr_hit", h, 1);
        check("wr_rdata", rd, LINE_M);
        check("wr_lat", lat, 2);
        check("wr_fill_cnt", fill_cnt, 1);
        check("wr_wb_cnt", wb_cnt, 0);
        check("wr_hit_cnt", hit_cnt, 2);

        for (int k = 1; k <= 3; k++) begin
            a = 32'h0000_1040 + k * 32'h2000;
            do_req(0, a, '0, 64'hFFFF, h, rd, lat);
            check("fillk_hit", h, 0);
            check("fillk_rdata", rd, {16{32'h5A5A_0000 | a}});
            check("fillk_addr", fill_addr, a);
        end
        check("fillk_wb_cnt", wb_cnt, 0);

        stall = 5;
        do_req(0, 32'h0000_9040, '0, 64'h0, h, rd, lat);
        check("evict_hit", h, 0);
        check("evict_wb_cnt", wb_cnt, 1);
        check("evict_wb_addr", wb_addr, 32'h0000_1040);
        check("evict_wb_data", wb_data, LINE_M);
        check("evict_fill_addr", fill_addr, 32'h0000_9040);
        check("evict_rdata", rd, LINE_9);
        check("evict_stall_used", stall, 0);
        check("evict_miss_cnt", miss_cnt, 5);

        pulse_reset();
        do_req(0, 32'h0000_1040, '0, 64'h0, h, rd, lat);
        check("re_miss_hit", h, 0);
        check("re_miss_rdata", rd, LINE_M);
        for (int k = 1; k <= 3; k++) begin
            do_req(0, 32'h0000_1040 + k * 32'h2000, '0, 64'h0, h, rd, lat);
            check("re_fillk_hit", h, 0);
        end
        do_req(0, 32'h0000_1040, '0, 64'h0, h, rd, lat);
        check("re_touch_hit", h, 1);
        wbs = wb_cnt;
        do_req(0, 32'h0000_9040, '0, 64'h0, h, rd, lat);
        check("clean_evict_hit", h, 0);
        check("clean_evict_no_wb", wb_cnt, wbs);
        check("clean_evict_fill", fill_addr, 32'h0000_9040);
        do_req(0, 32'h0000_1040, '0, 64'h0, h, rd, lat);
        check("mru_kept_hit", h, 1);
        do_req(0, 32'h0000_3040, '0, 64'h0, h, rd, lat);
        check("lru_gone_hit", h, 0);
        check("re_hit_cnt", hit_cnt, 2);
        check("re_miss_cnt", miss_cnt, 6);

        rst_in_fill = 1;
        do_req(0, 32'h0000_B040, '0, 64'h0, h, rd, lat);
        #1;
        check("abort_seen", aborted, 1);
        check("abort_req_ready", req_ready, 0);
        check("abort_mem_valid", mem_req_valid, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_miss_cnt", miss_cnt, 0);
        rst_in_fill = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_no_resp", resp_valid, 0);
        end
        rst = 0;
        #1;
        check("abort_rel_ready", req_ready, 1);
        do_req(0, 32'h0000_1040, '0, 64'h0, h, rd, lat);
        check("post_abort_hit", h, 0);
        check("post_abort_rdata", rd, LINE_M);
        check("post_abort_miss_cnt", miss_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
